// File: rtl/dpram_pkg.sv
// Shared types and constants for the dual-port RAM and its clear sequencer.
package dpram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   // Bit replicated across a word to form the default sweep value.
   localparam logic DefaultClearBit = 1'b0;

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset sweep sequencer: walks every address once, then hands the array to the ports.
module dpram_clear_seq
   import dpram_pkg::*;
#(
   parameter int AddressSize  = 16,
   parameter bit ClearOnReset = 1'b1
)
(
   input  logic                   i_clk,
   input  logic                   i_reset,
   output logic                   o_busy,
   output logic [AddressSize-1:0] o_clearAddr,
   output logic                   o_clearWe
);

   state_t                 r_state;
   state_t                 w_nextState;
   logic [AddressSize-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         if (ClearOnReset) begin
            r_state <= CLEAR;
         end else begin
            r_state <= READY;
         end
         r_count <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == CLEAR) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // The last sweep write happens at the all-ones address; the counter wraps to zero with it.
   always_comb begin
      w_nextState = r_state;
      if ((r_state == CLEAR) && (r_count == '1)) begin
         w_nextState = READY;
      end
   end

   assign o_busy      = (r_state == CLEAR);
   assign o_clearWe   = (r_state == CLEAR);
   assign o_clearAddr = r_count;

endmodule

// File: rtl/dpram.sv
// Dual-port synchronous RAM with read-first registered reads, post-reset clear sweep and error flags.
module dpram
   import dpram_pkg::*;
#(
   parameter int                     AddressSize  = 16,
   parameter int                     WordSize     = 8,
   parameter bit                     ClearOnReset = 1'b1,
   parameter logic [WordSize-1:0]    ClearValue   = {WordSize{DefaultClearBit}}
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [AddressSize-1:0] AddrA,
   input  logic [AddressSize-1:0] AddrB,
   input  logic [WordSize-1:0]    InDataA,
   input  logic [WordSize-1:0]    InDataB,
   output logic [WordSize-1:0]    OutDataA,
   output logic [WordSize-1:0]    OutDataB,
   input  logic                   CSA,
   input  logic                   WEA,
   input  logic                   OEA,
   input  logic                   CSB,
   input  logic                   WEB,
   input  logic                   OEB,
   output logic                   Busy,
   output logic                   Collide,
   output logic                   CtlErr
);

   localparam int Depth = 1 << AddressSize;

   logic [WordSize-1:0]    r_mem [Depth];
   logic [WordSize-1:0]    r_rdataA;
   logic [WordSize-1:0]    r_rdataB;
   logic                   r_collide;
   logic                   r_ctlErr;

   logic                   w_busy;
   logic                   w_ready;
   logic                   w_clearWe;
   logic [AddressSize-1:0] w_clearAddr;
   logic                   w_portWrA;
   logic                   w_portWrB;
   logic                   w_portRdA;
   logic                   w_portRdB;
   logic                   w_wrEnA;
   logic [AddressSize-1:0] w_wrAddrA;
   logic [WordSize-1:0]    w_wrDataA;
   logic                   w_ctlErrNow;

   dpram_clear_seq #(
      .AddressSize  (AddressSize),
      .ClearOnReset (ClearOnReset)
   ) u_clearSeq (
      .i_clk       (clk),
      .i_reset     (reset),
      .o_busy      (w_busy),
      .o_clearAddr (w_clearAddr),
      .o_clearWe   (w_clearWe)
   );

   assign w_ready   = ~w_busy;
   assign w_portWrA = w_ready & ~CSA & ~WEA;
   assign w_portWrB = w_ready & ~CSB & ~WEB;
   assign w_portRdA = w_ready & ~CSA &  WEA;
   assign w_portRdB = w_ready & ~CSB &  WEB;

   // The sweep borrows port A's write path; ports are idle while it runs.
   assign w_wrEnA   = w_clearWe | w_portWrA;
   assign w_wrAddrA = w_clearWe ? w_clearAddr : AddrA;
   assign w_wrDataA = w_clearWe ? ClearValue  : InDataA;

   assign w_ctlErrNow = (~CSA & ~WEA & ~OEA) | (~CSB & ~WEB & ~OEB);

   // Port A is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_portWrB) begin
            r_mem[AddrB] <= InDataB;
         end
         if (w_wrEnA) begin
            r_mem[w_wrAddrA] <= w_wrDataA;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdataA  <= '0;
         r_rdataB  <= '0;
         r_collide <= 1'b0;
         r_ctlErr  <= 1'b0;
      end else begin
         if (w_portRdA) begin
            r_rdataA <= r_mem[AddrA];
         end
         if (w_portRdB) begin
            r_rdataB <= r_mem[AddrB];
         end
         r_collide <= w_portWrA & w_portWrB & (AddrA == AddrB);
         if (w_ctlErrNow) begin
            r_ctlErr <= 1'b1;
         end
      end
   end

   assign OutDataA = OEA ? {WordSize{1'bz}} : r_rdataA;
   assign OutDataB = OEB ? {WordSize{1'bz}} : r_rdataB;
   assign Busy     = w_busy;
   assign Collide  = r_collide;
   assign CtlErr   = r_ctlErr;

endmodule

// File: tb/tb_dpram.sv
// Randomised scoreboard bench for dpram (16 words x 8 bits, sweep value A5).
module tb_dpram;

   localparam int AW    = 4;
   localparam int Depth = 1 << AW;

   logic          clk;
   logic          reset;
   logic [AW-1:0] addrA, addrB;
   logic [7:0]    inDataA, inDataB;
   wire  [7:0]    outDataA, outDataB;
   logic          csA, weA, oeA, csB, weB, oeB;
   logic          busy, collide, ctlErr;

   int testsRun  = 0;
   int failCount = 0;

   typedef struct {
      int         sig;
      logic [7:0] exp;
   } check_t;

   check_t expQ[$];

   logic [7:0] mMem [Depth];
   logic [7:0] mRdA, mRdB;
   logic       mCollide, mCtlErr, mBusy;
   int         clearLeft;

   dpram #(
      .AddressSize  (AW),
      .WordSize     (8),
      .ClearOnReset (1'b1),
      .ClearValue   (8'hA5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .AddrA    (addrA),
      .AddrB    (addrB),
      .InDataA  (inDataA),
      .InDataB  (inDataB),
      .OutDataA (outDataA),
      .OutDataB (outDataB),
      .CSA      (csA),
      .WEA      (weA),
      .OEA      (oeA),
      .CSB      (csB),
      .WEB      (weB),
      .OEB      (oeB),
      .Busy     (busy),
      .Collide  (collide),
      .CtlErr   (ctlErr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic string sigName(input int s);
      case (s)
         0:       return "OutDataA";
         1:       return "OutDataB";
         2:       return "OutDataA_released";
         3:       return "OutDataB_released";
         4:       return "Busy";
         5:       return "Collide";
         default: return "CtlErr";
      endcase
   endfunction

   // Monitor: everything queued for an edge is compared just after that edge.
   initial begin
      check_t     c;
      logic [7:0] act;
      bit         ok;
      forever begin
         @(posedge clk);
         #1;
         while (expQ.size() > 0) begin
            c = expQ.pop_front();
            case (c.sig)
               0:       begin act = outDataA;       ok = (act === c.exp); end
               1:       begin act = outDataB;       ok = (act === c.exp); end
               2:       begin act = outDataA;       ok = $isunknown(act) || (act == 8'h00); end
               3:       begin act = outDataB;       ok = $isunknown(act) || (act == 8'h00); end
               4:       begin act = {7'b0, busy};    ok = (act === c.exp); end
               5:       begin act = {7'b0, collide}; ok = (act === c.exp); end
               default: begin act = {7'b0, ctlErr};  ok = (act === c.exp); end
            endcase
            testsRun++;
            if (!ok) begin
               failCount++;
               if (c.sig == 2 || c.sig == 3) begin
                  $display("[TB] FAIL %s at %0t: got %h, expected high-impedance", sigName(c.sig), $time, act);
               end else begin
                  $display("[TB] FAIL %s at %0t: got %h, expected %h", sigName(c.sig), $time, act, c.exp);
               end
            end
         end
      end
   end

   // Drives one clock's worth of inputs, advances the reference model and queues what the edge must produce.
   task automatic applyStimulus(
      input logic rst,
      input logic cA, input logic wA, input logic oA, input logic [AW-1:0] aA, input logic [7:0] dA,
      input logic cB, input logic wB, input logic oB, input logic [AW-1:0] aB, input logic [7:0] dB);
      logic wrA, wrB;
      @(negedge clk);
      reset = rst;
      csA = cA; weA = wA; oeA = oA; addrA = aA; inDataA = dA;
      csB = cB; weB = wB; oeB = oB; addrB = aB; inDataB = dB;

      if (rst) begin
         mRdA = 8'h00; mRdB = 8'h00;
         mCollide = 1'b0; mCtlErr = 1'b0;
         clearLeft = Depth;
         mBusy = 1'b1;
      end else begin
         if ((!cA && !wA && !oA) || (!cB && !wB && !oB)) mCtlErr = 1'b1;
         if (clearLeft > 0) begin
            mMem[Depth - clearLeft] = 8'hA5;
            clearLeft--;
            mCollide = 1'b0;
            mBusy = (clearLeft > 0);
         end else begin
            wrA = !cA && !wA;
            wrB = !cB && !wB;
            if (!cA && wA) mRdA = mMem[aA];
            if (!cB && wB) mRdB = mMem[aB];
            if (wrB) mMem[aB] = dB;
            if (wrA) mMem[aA] = dA;
            mCollide = wrA && wrB && (aA == aB);
            mBusy = 1'b0;
         end
      end

      if (!oA) expQ.push_back('{0, mRdA}); else expQ.push_back('{2, 8'h00});
      if (!oB) expQ.push_back('{1, mRdB}); else expQ.push_back('{3, 8'h00});
      expQ.push_back('{4, {7'b0, mBusy}});
      expQ.push_back('{5, {7'b0, mCollide}});
      expQ.push_back('{6, {7'b0, mCtlErr}});
   endtask

   task automatic idle(input logic rst, input int n);
      for (int i = 0; i < n; i++) applyStimulus(rst, 1, 1, 1, '0, 8'h00, 1, 1, 1, '0, 8'h00);
   endtask

   task automatic readAll();
      for (int i = 0; i < Depth; i++) begin
         applyStimulus(0, 0, 1, 0, AW'(i), 8'h00, 0, 1, 0, AW'(Depth - 1 - i), 8'h00);
      end
   endtask

   task automatic checkOutput();
      logic [31:0] r;
      logic [AW-1:0] aB;
      for (int i = 0; i < 400; i++) begin
         r  = $urandom;
         aB = r[28] ? r[7:4] : r[23:20];
         applyStimulus(($urandom_range(0, 149) == 0),
                       r[0] & r[1], r[2], r[3], r[7:4], r[15:8],
                       r[16] & r[17], r[18], r[19], aB, r[31:24]);
      end
   endtask

   initial begin
      reset = 1'b1;
      csA = 1'b1; weA = 1'b1; oeA = 1'b1; addrA = '0; inDataA = 8'h00;
      csB = 1'b1; weB = 1'b1; oeB = 1'b1; addrB = '0; inDataB = 8'h00;
      clearLeft = 0;
      mRdA = 8'h00; mRdB = 8'h00; mCollide = 1'b0; mCtlErr = 1'b0; mBusy = 1'b1;
      for (int i = 0; i < Depth; i++) mMem[i] = 8'h00;

      // Initial sweep, then overwrite everything with zero and sweep again.
      idle(1, 2);
      idle(0, Depth + 1);
      for (int i = 0; i < Depth; i++) applyStimulus(0, 0, 0, 1, AW'(i), 8'h00, 1, 1, 1, '0, 8'h00);
      idle(1, 1);
      idle(0, Depth);
      readAll();

      // Basic cross-port write then read, then port A released.
      applyStimulus(0, 0, 0, 1, 4'd5, 8'h3C, 0, 0, 1, 4'd9, 8'hC3);
      applyStimulus(0, 0, 1, 0, 4'd9, 8'h00, 0, 1, 0, 4'd5, 8'h00);
      applyStimulus(0, 1, 1, 1, 4'd0, 8'h00, 1, 1, 0, 4'd0, 8'h00);

      // Read-first on a cross-port read of the word being written.
      applyStimulus(0, 0, 0, 1, 4'd7, 8'h11, 1, 1, 1, 4'd0, 8'h00);
      applyStimulus(0, 0, 0, 1, 4'd7, 8'h22, 0, 1, 0, 4'd7, 8'h00);
      applyStimulus(0, 1, 1, 1, 4'd0, 8'h00, 0, 1, 0, 4'd7, 8'h00);
      applyStimulus(0, 0, 0, 1, 4'd8, 8'h44, 0, 1, 0, 4'd8, 8'h00);
      applyStimulus(0, 0, 1, 0, 4'd8, 8'h00, 1, 1, 0, 4'd0, 8'h00);

      // Same-address and different-address dual writes.
      applyStimulus(0, 0, 0, 1, 4'd3, 8'hAA, 0, 0, 1, 4'd3, 8'hBB);
      idle(0, 1);
      applyStimulus(0, 0, 0, 1, 4'd1, 8'h12, 0, 0, 1, 4'd2, 8'h34);
      applyStimulus(0, 0, 1, 0, 4'd3, 8'h00, 0, 1, 0, 4'd2, 8'h00);
      applyStimulus(0, 0, 1, 0, 4'd1, 8'h00, 1, 1, 0, 4'd0, 8'h00);

      // Reset during the sweep, with port writes attempted throughout.
      idle(1, 1);
      idle(0, 6);
      idle(1, 2);
      for (int i = 0; i < Depth; i++) applyStimulus(0, 0, 0, 1, AW'(i), 8'h5A, 0, 0, 1, AW'(i), 8'h6B);
      readAll();

      // Illegal control combination on port B; the write must still happen.
      applyStimulus(0, 1, 1, 1, 4'd0, 8'h00, 0, 0, 0, 4'd2, 8'h5A);
      idle(0, 3);
      applyStimulus(0, 0, 1, 0, 4'd2, 8'h00, 1, 1, 1, 4'd0, 8'h00);
      idle(1, 1);
      idle(0, Depth);

      checkOutput();

      idle(0, 2);
      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
